// File: rtl/vga_pkg.sv
// Shared VGA timing constants, coordinate widths and small decode helpers.
// Sprite blocks import this for COL_W/ROW_W so coordinate buses stay consistent.
package vga_pkg;

  // 640x480@60 Hz timing (pixels / lines)
  localparam int H_VIS  = 640;
  localparam int H_FP   = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP   = 48;
  localparam int V_VIS  = 480;
  localparam int V_FP   = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 33;

  localparam int H_TOT    = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT    = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_VIS + H_FP;
  localparam int HS_END   = HS_START + H_SYNC - 1;
  localparam int VS_START = V_VIS + V_FP;
  localparam int VS_END   = VS_START + V_SYNC - 1;

  // Coordinate bus widths shared with every sprite consumer
  localparam int COL_W = 10;
  localparam int ROW_W = 9;
  localparam int CNT_W = 10;
  localparam int FC_W  = 8;

  // Raster position (internal scan counters)
  typedef struct packed {
    logic [CNT_W-1:0] h;
    logic [CNT_W-1:0] v;
  } vga_pos_t;

  // Decoded per-pixel flags; syncs are active low
  typedef struct packed {
    logic video_on;
    logic hsync;
    logic vsync;
  } vga_sync_t;

  // True when counter value c lies in the inclusive window [lo, hi]
  function automatic logic in_win(input logic [CNT_W-1:0] c, input int lo, input int hi);
    return (int'(c) >= lo) && (int'(c) <= hi);
  endfunction

endpackage

// File: rtl/vga_pix_div.sv
// Pixel clock-enable divider: one advance strobe every PIX_DIV enabled clks.
// PIX_DIV = 1 degenerates to an advance on every enabled clk.
module vga_pix_div #(
  parameter int PIX_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  output logic o_adv
);

  localparam int DW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(PIX_DIV - 1);

  logic [DW-1:0] r_div;

  // The wrap cycle is the advance cycle
  assign o_adv = i_en && (r_div == LAST);

  // Divider count, frozen while disabled
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     r_div <= '0;
    else if (i_en) r_div <= (r_div == LAST) ? '0 : r_div + DW'(1);
  end

endmodule

// File: rtl/vga_scan_gen.sv
// Raster scan generator: h/v counters advanced by the pixel divider, decoded
// to row/col, blanking and active-low syncs, all presented through one
// output register stage. Also provides frame_start / frame_count so sprite
// animation can key off frames instead of long free-running counters.
module vga_scan_gen
  import vga_pkg::*;
#(
  parameter int PIX_DIV = 2,
  parameter int H_VIS   = vga_pkg::H_VIS,
  parameter int H_FP    = vga_pkg::H_FP,
  parameter int H_SYNC  = vga_pkg::H_SYNC,
  parameter int H_BP    = vga_pkg::H_BP,
  parameter int V_VIS   = vga_pkg::V_VIS,
  parameter int V_FP    = vga_pkg::V_FP,
  parameter int V_SYNC  = vga_pkg::V_SYNC,
  parameter int V_BP    = vga_pkg::V_BP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic             pix_tick,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             video_on,
  output logic             hsync,
  output logic             vsync,
  output logic             frame_start,
  output logic [FC_W-1:0]  frame_count
);

  localparam int L_H_TOT    = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int L_V_TOT    = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int L_HS_START = H_VIS + H_FP;
  localparam int L_HS_END   = L_HS_START + H_SYNC - 1;
  localparam int L_VS_START = V_VIS + V_FP;
  localparam int L_VS_END   = L_VS_START + V_SYNC - 1;

  localparam logic [CNT_W-1:0] C_H_LAST = CNT_W'(L_H_TOT - 1);
  localparam logic [CNT_W-1:0] C_V_LAST = CNT_W'(L_V_TOT - 1);
  localparam logic [CNT_W-1:0] C_H_VIS  = CNT_W'(H_VIS);
  localparam logic [CNT_W-1:0] C_V_VIS  = CNT_W'(V_VIS);

  logic      w_adv;
  logic      w_land0;
  vga_pos_t  r_pos;
  vga_pos_t  w_pos_nxt;
  vga_sync_t w_dec;
  logic      w_hvis;
  logic      w_vvis;

  logic      r_pix_tick;
  logic      r_land0;
  logic      r_frame_start;
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  vga_sync_t        r_sync;
  logic [FC_W-1:0]  r_frame_count;

  vga_pix_div #(
    .PIX_DIV (PIX_DIV)
  ) u_pix_div (
    .clk   (clk),
    .reset (reset),
    .i_en  (en),
    .o_adv (w_adv)
  );

  // Next raster position: h wraps at line end and carries into v
  always_comb begin
    w_pos_nxt = r_pos;
    if (w_adv) begin
      if (r_pos.h == C_H_LAST) begin
        w_pos_nxt.h = '0;
        w_pos_nxt.v = (r_pos.v == C_V_LAST) ? '0 : r_pos.v + CNT_W'(1);
      end else begin
        w_pos_nxt.h = r_pos.h + CNT_W'(1);
      end
    end
  end

  // An advance that lands on (0,0) starts a new frame
  assign w_land0 = w_adv && (w_pos_nxt.h == '0) && (w_pos_nxt.v == '0);

  // Scan counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_pos <= '0;
    else       r_pos <= w_pos_nxt;
  end

  // Decode of the current (post-advance) raster position
  always_comb begin
    w_hvis         = (r_pos.h < C_H_VIS);
    w_vvis         = (r_pos.v < C_V_VIS);
    w_dec.video_on = w_hvis && w_vvis;
    w_dec.hsync    = ~in_win(r_pos.h, L_HS_START, L_HS_END);
    w_dec.vsync    = ~in_win(r_pos.v, L_VS_START, L_VS_END);
  end

  // Output stage; r_land0 keeps a frame landing pending across an en pause
  // so the frame_start pulse is never lost
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pix_tick    <= 1'b0;
      r_land0       <= 1'b0;
      r_frame_start <= 1'b0;
      r_col         <= '0;
      r_row         <= '0;
      r_sync        <= '{video_on: 1'b0, hsync: 1'b1, vsync: 1'b1};
      r_frame_count <= '0;
    end else begin
      r_pix_tick    <= w_adv;
      r_frame_start <= 1'b0;
      if (w_land0)  r_land0 <= 1'b1;
      else if (en)  r_land0 <= 1'b0;
      if (en) begin
        r_col  <= w_hvis ? r_pos.h[COL_W-1:0] : '0;
        r_row  <= w_vvis ? r_pos.v[ROW_W-1:0] : '0;
        r_sync <= w_dec;
        if (r_land0) begin
          r_frame_start <= 1'b1;
          r_frame_count <= r_frame_count + FC_W'(1);
        end
      end
    end
  end

  assign pix_tick    = r_pix_tick;
  assign col         = r_col;
  assign row         = r_row;
  assign video_on    = r_sync.video_on;
  assign hsync       = r_sync.hsync;
  assign vsync       = r_sync.vsync;
  assign frame_start = r_frame_start;
  assign frame_count = r_frame_count;

endmodule
